// File: rtl/sm_cpu_pkg.sv
// ============================================================================
// Module  : sm_cpu_pkg
// Brief   : Shared widths, reset PC and fetch entry type for the sm CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_cpu_pkg;

  localparam int          XLEN             = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Byte PC to ROM word address.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_fetch_fifo.sv
// ============================================================================
// Module  : sm_fetch_fifo
// Brief   : Synchronous prefetch FIFO with flush and async active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Entries are left in place; only the bookkeeping restarts.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sm_fetch.sv
// ============================================================================
// Module  : sm_fetch
// Brief   : Instruction fetch stage: PC, ROM addressing, prefetch FIFO, redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_fetch
  import sm_cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [XLEN-1:0] r_pc;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_wentry;
  fetch_entry_t    w_head;

  // Push never looks at out_ready, so decode stalls cannot reach the ROM address.
  assign w_push = ~w_full & ~redirect;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pc <= RESET_PC;
    else if (redirect) r_pc <= redirect_pc & ~32'h3;
    else if (w_push) r_pc <= r_pc + 32'd4;
  end

  assign w_wentry = '{instr: im_data, pc: r_pc};

  sm_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata (w_wentry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign im_addr   = word_addr(r_pc);
  assign out_valid = ~w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

endmodule

`default_nettype wire
